object_renderer: RTL and testbench

//  Consumer side of the object-descriptor interface produced by the player/obstacle objects
//  (vStartPos, hStartPos, objWidth, objHeight, vOffset, hOffset, color).

---
 rtl/object_renderer_pkg.sv | 53 +++++
 rtl/obj_box_compare.sv | 26 ++
 rtl/object_renderer.sv | 125 ++++++++++++
 tb/tb_object_renderer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/object_renderer_pkg.sv
// Shared definitions for the object renderer: screen defaults, colour codes, box geometry.
// Box bounds are 33 bits so bottom/right edges never wrap.
package object_renderer_pkg;

  localparam int H_VISIBLE       = 640;
  localparam int V_VISIBLE_DEF   = 480;
  localparam logic [3:0] BG_COLOR_DEF = 4'd0;
  localparam int BOX_W           = 33;

  localparam logic [3:0] COL_BLACK  = 4'd0;
  localparam logic [3:0] COL_BLUE   = 4'd1;
  localparam logic [3:0] COL_RED    = 4'd2;
  localparam logic [3:0] COL_GREEN  = 4'd3;
  localparam logic [3:0] COL_YELLOW = 4'd4;
  localparam logic [3:0] COL_WHITE  = 4'd15;

  typedef enum logic {
    EMPTY   = 1'b0,
    SHOWING = 1'b1
  } rendState_t;

  typedef struct packed {
    logic [BOX_W-1:0] top;
    logic [BOX_W-1:0] bot;
    logic [BOX_W-1:0] left;
    logic [BOX_W-1:0] right;
    logic [3:0]       color;
  } objBox_t;

  // Origin wraps mod 2^32; extent is added in 33 bits (exclusive bounds).
  function automatic objBox_t makeBox(
    input logic [31:0] vStart,
    input logic [31:0] hStart,
    input logic [31:0] width,
    input logic [31:0] height,
    input logic [31:0] vOff,
    input logic [31:0] hOff,
    input logic [3:0]  color
  );
    objBox_t    b;
    logic [31:0] t;
    logic [31:0] l;
    t       = vStart + vOff;
    l       = hStart + hOff;
    b.top   = {1'b0, t};
    b.left  = {1'b0, l};
    b.bot   = {1'b0, t} + {1'b0, height};
    b.right = {1'b0, l} + {1'b0, width};
    b.color = color;
    return b;
  endfunction

endpackage

// File: rtl/obj_box_compare.sv
// Registered half-open range test lo <= count < hi on a zero-extended pixel counter.
// One cycle latency, no backpressure.
module obj_box_compare
  import object_renderer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       count,
  input  logic [BOX_W-1:0] lo,
  input  logic [BOX_W-1:0] hi,
  output logic             inRange
);

  logic [BOX_W-1:0] countExt;

  assign countExt = {{(BOX_W-10){1'b0}}, count};

  always_ff @(posedge clk) begin
    if (!rst) begin
      inRange <= 1'b0;
    end else begin
      inRange <= (countExt >= lo) && (countExt < hi);
    end
  end

endmodule

// File: rtl/object_renderer.sv
// Double-buffered object descriptor renderer: per-pixel colour/hit at 2-cycle latency plus frame flags.
// desc_ready drops while a descriptor waits for the next frame boundary; pixel path never stalls.
module object_renderer #(
  parameter int         V_VISIBLE = object_renderer_pkg::V_VISIBLE_DEF,
  parameter logic [3:0] BG_COLOR  = object_renderer_pkg::BG_COLOR_DEF
) (
  input  logic        pixClk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] obj_vStartPos,
  input  logic [31:0] obj_hStartPos,
  input  logic [31:0] obj_objWidth,
  input  logic [31:0] obj_objHeight,
  input  logic [31:0] obj_vOffset,
  input  logic [31:0] obj_hOffset,
  input  logic [3:0]  obj_color,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        blank,
  output logic [3:0]  pix_color,
  output logic        pix_hit,
  output logic        frame_start,
  output logic        frame_hit
);

  import object_renderer_pkg::*;

  rendState_t state;
  rendState_t stateNext;
  objBox_t    pendBox;
  objBox_t    actBox;
  logic       pendingFull;
  logic       captureEn;
  logic       boundary;
  logic       promote;
  logic       activeValid;
  logic       inV;
  logic       inH;
  logic       blankS1;
  logic       hitS1;
  logic       acc;

  assign boundary    = (hCount == 10'd0) && (vCount == 10'(V_VISIBLE));
  assign desc_ready  = rst & ~pendingFull;
  assign captureEn   = desc_valid & desc_ready;
  assign promote     = boundary & pendingFull;
  assign activeValid = (state == SHOWING);

  always_ff @(posedge pixClk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      EMPTY:   if (promote) stateNext = SHOWING;
      SHOWING: stateNext = SHOWING;
      default: stateNext = EMPTY;
    endcase
  end

  // Capture requires an empty pending slot, so it can never coincide with a promotion.
  always_ff @(posedge pixClk) begin
    if (!rst) begin
      pendingFull <= 1'b0;
      pendBox     <= '0;
      actBox      <= '0;
    end else if (promote) begin
      actBox      <= pendBox;
      pendingFull <= 1'b0;
    end else if (captureEn) begin
      pendBox     <= makeBox(obj_vStartPos, obj_hStartPos, obj_objWidth, obj_objHeight,
                             obj_vOffset, obj_hOffset, obj_color);
      pendingFull <= 1'b1;
    end
  end

  obj_box_compare uVCmp (
    .clk     (pixClk),
    .rst     (rst),
    .count   (vCount),
    .lo      (actBox.top),
    .hi      (actBox.bot),
    .inRange (inV)
  );

  obj_box_compare uHCmp (
    .clk     (pixClk),
    .rst     (rst),
    .count   (hCount),
    .lo      (actBox.left),
    .hi      (actBox.right),
    .inRange (inH)
  );

  assign hitS1 = activeValid & inV & inH & ~blankS1;

  always_ff @(posedge pixClk) begin
    if (!rst) begin
      blankS1     <= 1'b0;
      pix_hit     <= 1'b0;
      pix_color   <= BG_COLOR;
      frame_start <= 1'b0;
      frame_hit   <= 1'b0;
      acc         <= 1'b0;
    end else begin
      blankS1     <= blank;
      pix_hit     <= hitS1;
      pix_color   <= hitS1 ? actBox.color : BG_COLOR;
      frame_start <= boundary;
      if (boundary) begin
        frame_hit <= acc | pix_hit;
        acc       <= 1'b0;
      end else begin
        acc       <= acc | pix_hit;
      end
    end
  end

endmodule

// File: tb/tb_object_renderer.sv
// Scoreboard bench for object_renderer: randomized and directed pixel scans against a box-geometry model.
module tb_object_renderer;

  logic        pixClk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] objV = '0, objH = '0, objW = '0, objHt = '0, objVo = '0, objHo = '0;
  logic [3:0]  objC = '0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic        blank = 1'b1;
  logic [3:0]  pix_color;
  logic        pix_hit, frame_start, frame_hit;

  object_renderer dut (
    .pixClk(pixClk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .obj_vStartPos(objV), .obj_hStartPos(objH), .obj_objWidth(objW), .obj_objHeight(objHt),
    .obj_vOffset(objVo), .obj_hOffset(objHo), .obj_color(objC),
    .hCount(hCount), .vCount(vCount), .blank(blank),
    .pix_color(pix_color), .pix_hit(pix_hit), .frame_start(frame_start), .frame_hit(frame_hit)
  );

  always #5 pixClk = ~pixClk;

  typedef struct { longint unsigned top, bot, left, right; bit [3:0] color; } mBox_t;
  typedef struct { int due; bit [3:0] color; bit hit; } pixExp_t;
  typedef struct { int due; bit fs; bit fh; bit rdy; } frmExp_t;

  pixExp_t pixQ[$];
  frmExp_t frmQ[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mBox_t mPend, mAct;
  bit    mPendFull = 0, mActValid = 0, mAcc = 0, mFrameHit = 0;
  bit    scanValid = 0;

  always @(posedge pixClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever expectations fall due this cycle.
  pixExp_t pe;
  frmExp_t fe;
  always @(negedge pixClk) begin
    while (pixQ.size() > 0 && pixQ[0].due <= cyc) begin
      pe = pixQ.pop_front();
      check("pix_color", pix_color, pe.color);
      check("pix_hit", pix_hit, pe.hit);
    end
    while (frmQ.size() > 0 && frmQ[0].due <= cyc) begin
      fe = frmQ.pop_front();
      check("frame_start", frame_start, fe.fs);
      check("frame_hit", frame_hit, fe.fh);
      check("desc_ready", desc_ready, fe.rdy);
    end
  end

  function automatic mBox_t mkBox();
    mBox_t b;
    logic [31:0] t, l;
    t = objV + objVo;
    l = objH + objHo;
    b.top   = longint'(t);
    b.left  = longint'(l);
    b.bot   = b.top + longint'(objHt);
    b.right = b.left + longint'(objW);
    b.color = objC;
    return b;
  endfunction

  function automatic void modelReset();
    mPendFull = 0; mActValid = 0; mAcc = 0; mFrameHit = 0;
  endfunction

  // Drive one pixel cycle and record what the DUT must show for it.
  task automatic step(input int h, input int v, input bit b, input bit val);
    bit      bnd, hit;
    pixExp_t p;
    frmExp_t f;
    hCount = 10'(h); vCount = 10'(v); blank = b; desc_valid = val;
    bnd = (h == 0) && (v == 480);
    hit = mActValid && !b && v >= mAct.top && v < mAct.bot && h >= mAct.left && h < mAct.right;
    p.due = cyc + 2; p.hit = hit; p.color = hit ? mAct.color : 4'd0;
    pixQ.push_back(p);
    if (bnd) begin mFrameHit = mAcc; mAcc = hit; end
    else mAcc = mAcc | hit;
    if (bnd && mPendFull) begin mAct = mPend; mActValid = 1; mPendFull = 0; end
    else if (val && !mPendFull) begin mPend = mkBox(); mPendFull = 1; end
    f.due = cyc + 1; f.fs = bnd; f.fh = mFrameHit; f.rdy = !mPendFull;
    frmQ.push_back(f);
    @(posedge pixClk); #1;
  endtask

  task automatic raw(input int h, input int v, input bit b);
    hCount = 10'(h); vCount = 10'(v); blank = b; desc_valid = 1'b0;
    @(posedge pixClk); #1;
  endtask

  task automatic frameEnd();
    step(650, 479, 1, scanValid);
    step(700, 479, 1, scanValid);
    step(0, 480, 1, scanValid);
  endtask

  task automatic scanRect(input int v0, input int v1, input int h0, input int h1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        step(h, v, (h >= 640) || ($urandom_range(0, 15) == 0), scanValid);
  endtask

  function automatic int nearEdge(input longint unsigned e, input int maxv);
    int r;
    if ($urandom_range(0, 1) == 1 && e < longint'(maxv + 4)) r = int'(e) + int'($urandom_range(0, 6)) - 3;
    else r = int'($urandom_range(0, maxv));
    if (r < 0) r = 0;
    if (r > maxv) r = maxv;
    return r;
  endfunction

  task automatic randDesc();
    objV = $urandom_range(0, 500); objH = $urandom_range(0, 660);
    objW = $urandom_range(0, 40);  objHt = $urandom_range(0, 40);
    objVo = 32'($urandom_range(0, 20)) - 32'd10;
    objHo = 32'($urandom_range(0, 20)) - 32'd10;
    objC = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 9))
      0: objW = 32'd0;
      1: objHt = 32'd0;
      2: objW = 32'hFFFF_FFFF;
      3: begin objV = 32'hFFFF_FFF8; objVo = 32'h10; end
      default: ;
    endcase
  endtask

  task automatic scanRandom(input int n, input bit withDesc);
    mBox_t ref_b;
    int h, v;
    bit val;
    for (int i = 0; i < n; i++) begin
      ref_b = mActValid ? mAct : mPend;
      if (mActValid || mPendFull) begin
        v = nearEdge($urandom_range(0, 1) ? ref_b.top : ref_b.bot, 479);
        h = nearEdge($urandom_range(0, 1) ? ref_b.left : ref_b.right, 655);
      end else begin
        v = $urandom_range(0, 479); h = $urandom_range(0, 655);
      end
      val = withDesc && ($urandom_range(0, 19) == 0);
      if (withDesc) randDesc();
      step(h, v, (h >= 640) || ($urandom_range(0, 15) == 0), val);
    end
  endtask

  task automatic setDesc(input int v, input int h, input int w, input int ht,
                         input logic [31:0] vo, input logic [31:0] ho, input logic [3:0] c);
    objV = 32'(v); objH = 32'(h); objW = 32'(w); objHt = 32'(ht); objVo = vo; objHo = ho; objC = c;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) raw(5, 5, 0);
    check("rst_pix_color", pix_color, 4'd0);
    check("rst_pix_hit", pix_hit, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_frame_hit", frame_hit, 1'b0);
    check("rst_desc_ready", desc_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("ready_after_rst", desc_ready, 1'b1);
    modelReset();

    // No descriptor: background everywhere, no frame hit
    scanRandom(300, 0);
    frameEnd();

    // Descriptor mid-frame stays hidden until the boundary
    setDesc(384, 327, 12, 12, 0, 0, 4'd2);
    step(5, 10, 0, 1);
    scanRect(382, 397, 325, 340);
    frameEnd();
    scanRect(382, 397, 325, 340);
    frameEnd();

    // Pending full blocks the next descriptor until the boundary
    setDesc(100, 327, 20, 10, 0, 32'hFFFF_FFF4, 4'd5);
    step(5, 20, 0, 1);
    setDesc(100, 327, 0, 10, 0, 32'hFFFF_FFF4, 4'd7);
    scanValid = 1;
    repeat (5) step(20, 20, 0, 1);
    frameEnd();
    step(3, 0, 1, 1);
    scanValid = 0;
    scanRect(98, 111, 312, 338);
    frameEnd();
    // Zero-width box is now active
    scanRect(98, 111, 312, 338);
    frameEnd();

    // Box clipped at right edge, blank inside the box
    setDesc(200, 635, 12, 8, 0, 0, 4'd2);
    step(5, 30, 0, 1);
    frameEnd();
    scanRect(198, 209, 630, 647);
    step(636, 202, 1, 0);
    frameEnd();
    scanRect(300, 302, 0, 20);
    frameEnd();
    scanRect(199, 203, 633, 640);

    // Reset while SHOWING
    repeat (3) raw(636, 201, 0);
    check("pre_rst_hit", pix_hit, 1'b1);
    check("pre_rst_color", pix_color, 4'd2);
    rst = 1'b0;
    raw(636, 201, 0);
    check("midrst_pix_color", pix_color, 4'd0);
    check("midrst_pix_hit", pix_hit, 1'b0);
    check("midrst_desc_ready", desc_ready, 1'b0);
    check("midrst_frame_hit", frame_hit, 1'b0);
    rst = 1'b1;
    #1;
    check("postrst_desc_ready", desc_ready, 1'b1);
    modelReset();
    repeat (3) raw(636, 201, 0);
    check("postrst_pix_hit", pix_hit, 1'b0);
    check("postrst_pix_color", pix_color, 4'd0);
    scanRect(199, 203, 633, 640);
    frameEnd();

    // Randomized frames with random descriptor traffic
    for (int f = 0; f < 12; f++) begin
      scanRandom(400, 1);
      frameEnd();
    end
    scanRandom(100, 0);

    repeat (4) raw(700, 490, 1);
    check("scoreboard_drained", 64'(pixQ.size() + frmQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
